prob_led_array: RTL and testbench

Parametrised multi-channel probabilistic LED driver for the reaction-game datapath. It is the successor to the single-LED probability block. Each enabled channel lights with a level-selected probability on every draw and holds its value stable for a programmable number of cycles. An optional propagation mode raises a channel's probability when a neighbour was lit on the previous draw. It sits between the game-level controller (`enable`, `level`, `chan_mask`) and the board LED pins.

---
 rtl/prob_led_pkg.sv | 26 ++
 rtl/prob_lfsr.sv | 26 ++
 rtl/prob_led_array.sv | 114 +++++++++++
 tb/tb_prob_led_array.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/prob_led_pkg.sv
// rtl/prob_led_pkg.sv - shared types, threshold table and LFSR constants for prob_led_array
package prob_led_pkg;

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [15:0] SEED_SPREAD = 16'h9E37;

  // Out of 256: roughly 10%, 20%, 30%, 50% on-probability per draw.
  localparam logic [7:0] THRESH [4] = '{8'd26, 8'd51, 8'd77, 8'd128};

  function automatic logic [7:0] thresh_of(input int unsigned idx);
    logic [1:0] sel;
    sel = (idx > 3) ? 2'd3 : idx[1:0];
    return THRESH[sel];
  endfunction

  function automatic logic [15:0] chan_seed(input logic [15:0] base, input int unsigned idx);
    logic [31:0] prod;
    logic [15:0] s;
    prod = idx * 32'(SEED_SPREAD);
    s    = base ^ prod[15:0];
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/prob_lfsr.sv
// rtl/prob_lfsr.sv - 16-bit Galois LFSR, steps every cycle outside reset
module prob_lfsr #(
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] out
);
  import prob_led_pkg::*;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/prob_led_array.sv
// rtl/prob_led_array.sv - multi-channel probabilistic LED driver with hold timer and neighbour boost
module prob_led_array #(
  parameter int          NUM_LED     = 18,
  parameter int          NUM_LEVELS  = 4,
  parameter int          HOLD_CYCLES = 1,
  parameter int          PROPAGATE   = 0,
  parameter int          BOOST       = 64,
  parameter logic [15:0] SEED        = 16'hACE1,
  localparam int         LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int         CW = $clog2(NUM_LED + 1),
  localparam int         HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [LW-1:0]      level,
  input  logic [NUM_LED-1:0] chan_mask,
  output logic [NUM_LED-1:0] led,
  output logic [CW-1:0]      lit_count,
  output logic               draw_strobe
);
  import prob_led_pkg::*;

  logic [15:0]        rnd [NUM_LED];
  logic [NUM_LED-1:0] unused_hi;

  for (genvar g = 0; g < NUM_LED; g++) begin : g_lfsr
    prob_lfsr #(.SEED(chan_seed(SEED, g))) u_lfsr (
      .clk (clk),
      .rst (rst),
      .out (rnd[g])
    );
    assign unused_hi[g] = ^rnd[g][15:8];
  end

  state_t             state_q, state_d;
  logic [NUM_LED-1:0] led_q, led_d;
  logic [CW-1:0]      lit_q, lit_d;
  logic               strobe_q, strobe_d;
  logic [HW-1:0]      hold_q, hold_d;

  function automatic logic [CW-1:0] popcount(input logic [NUM_LED-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_LED; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  int unsigned        lvl_eff;
  logic [7:0]         base_t;
  logic [8:0]         boost_sum;
  logic [7:0]         boost_t;
  logic [NUM_LED+1:0] led_pad;
  logic [NUM_LED-1:0] draw;

  // Zero-padded led so the end channels see a single neighbour without wrap.
  always_comb begin
    lvl_eff = 32'(level);
    if (lvl_eff > 32'(NUM_LEVELS - 1)) lvl_eff = 32'(NUM_LEVELS - 1);
    base_t    = thresh_of(lvl_eff);
    boost_sum = {1'b0, base_t} + 9'(BOOST);
    boost_t   = boost_sum[8] ? 8'hFF : boost_sum[7:0];
    led_pad   = {1'b0, led_q, 1'b0};
    draw      = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      if ((PROPAGATE != 0) && (led_pad[i] || led_pad[i+2]))
        draw[i] = chan_mask[i] && (rnd[i][7:0] < boost_t);
      else
        draw[i] = chan_mask[i] && (rnd[i][7:0] < base_t);
    end
  end

  always_comb begin
    state_d  = state_q;
    led_d    = led_q;
    lit_d    = lit_q;
    strobe_d = 1'b0;
    hold_d   = hold_q;
    if (!enable) begin
      state_d = IDLE;
      led_d   = '0;
      lit_d   = '0;
    end else if (state_q == IDLE || hold_q == '0) begin
      state_d  = HOLD;
      led_d    = draw;
      lit_d    = popcount(draw);
      strobe_d = 1'b1;
      hold_d   = HW'(HOLD_CYCLES - 1);
    end else begin
      hold_d = hold_q - HW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      led_q    <= '0;
      lit_q    <= '0;
      strobe_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      lit_q    <= lit_d;
      strobe_q <= strobe_d;
      hold_q   <= hold_d;
    end
  end

  assign led         = led_q;
  assign lit_count   = lit_q;
  assign draw_strobe = strobe_q;

endmodule

// File: tb/tb_prob_led_array.sv
// tb/tb_prob_led_array.sv - self-checking bench for prob_led_array
module tb_prob_led_array;
  localparam int N = 18;
  localparam int NI = 4;
  localparam int P_HOLD  [NI] = '{1, 4, 1, 1};
  localparam int P_PROP  [NI] = '{0, 0, 1, 0};
  localparam int P_BOOST [NI] = '{64, 64, 230, 64};
  localparam int P_NLEV  [NI] = '{4, 4, 4, 3};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic [1:0]   level = 2'd0;
  logic [N-1:0] chan_mask = '1;
  logic [N-1:0] led [NI];
  logic [4:0]   lit [NI];
  logic         stb [NI];

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0]  ref_q [N];
  logic [N-1:0] m_led [NI];
  bit           m_run [NI];
  int           m_cnt [NI];
  logic         m_stb [NI];

  int           on_cnt [N];
  int           nb_cnt, nb_hit;
  logic [N-1:0] prev_pr;

  always #5 clk = ~clk;

  prob_led_array #(.NUM_LED(N), .HOLD_CYCLES(1)) u_h1 (
    .clk(clk), .rst(rst), .enable(enable), .level(level), .chan_mask(chan_mask),
    .led(led[0]), .lit_count(lit[0]), .draw_strobe(stb[0]));
  prob_led_array #(.NUM_LED(N), .HOLD_CYCLES(4)) u_h4 (
    .clk(clk), .rst(rst), .enable(enable), .level(level), .chan_mask(chan_mask),
    .led(led[1]), .lit_count(lit[1]), .draw_strobe(stb[1]));
  prob_led_array #(.NUM_LED(N), .HOLD_CYCLES(1), .PROPAGATE(1), .BOOST(230)) u_pr (
    .clk(clk), .rst(rst), .enable(enable), .level(level), .chan_mask(chan_mask),
    .led(led[2]), .lit_count(lit[2]), .draw_strobe(stb[2]));
  prob_led_array #(.NUM_LED(N), .NUM_LEVELS(3), .HOLD_CYCLES(1)) u_l3 (
    .clk(clk), .rst(rst), .enable(enable), .level(level), .chan_mask(chan_mask),
    .led(led[3]), .lit_count(lit[3]), .draw_strobe(stb[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] seed_of(input int i);
    int p;
    logic [15:0] s;
    p = i * 'h9E37;
    s = 16'hACE1 ^ p[15:0];
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  function automatic int thr(input int lvl, input int nlev);
    int l;
    l = (lvl > nlev - 1) ? nlev - 1 : lvl;
    case (l)
      0:       return 26;
      1:       return 51;
      2:       return 77;
      default: return 128;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) ref_q[i] = seed_of(i);
    for (int k = 0; k < NI; k++) begin
      m_led[k] = '0; m_run[k] = 0; m_cnt[k] = 0; m_stb[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [N-1:0] nl;
    bit nb;
    int t, r;
    for (int k = 0; k < NI; k++) begin
      if (!enable) begin
        m_led[k] = '0; m_run[k] = 0; m_stb[k] = 1'b0;
      end else if (!m_run[k] || m_cnt[k] == 0) begin
        nl = '0;
        for (int i = 0; i < N; i++) begin
          t = thr(int'(level), P_NLEV[k]);
          if (P_PROP[k] != 0) begin
            nb = 0;
            if (i > 0)     nb = nb | m_led[k][i-1];
            if (i < N - 1) nb = nb | m_led[k][i+1];
            if (nb) t = (t + P_BOOST[k] > 255) ? 255 : t + P_BOOST[k];
          end
          r = int'(ref_q[i] & 16'h00FF);
          nl[i] = chan_mask[i] && (r < t);
        end
        m_led[k] = nl; m_stb[k] = 1'b1; m_cnt[k] = P_HOLD[k] - 1; m_run[k] = 1;
      end else begin
        m_cnt[k] = m_cnt[k] - 1; m_stb[k] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++)
      ref_q[i] = (ref_q[i] >> 1) ^ (ref_q[i][0] ? 16'hB400 : 16'h0000);
  endtask

  task automatic check_outputs(input string ph);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s_led%0d", ph, k), 32'(led[k]), 32'(m_led[k]));
      check($sformatf("%s_lit%0d", ph, k), 32'(lit[k]), $countones(m_led[k]));
      check($sformatf("%s_stb%0d", ph, k), 32'(stb[k]), 32'(m_stb[k]));
    end
  endtask

  task automatic clear_tally();
    for (int i = 0; i < N; i++) on_cnt[i] = 0;
    nb_cnt = 0; nb_hit = 0; prev_pr = led[2];
  endtask

  task automatic tally(input bit en, input logic [N-1:0] msk);
    bit nb;
    for (int i = 0; i < N; i++) begin
      on_cnt[i] += int'(led[0][i]);
      if (en && msk[i]) begin
        nb = 0;
        if (i > 0)     nb = nb | prev_pr[i-1];
        if (i < N - 1) nb = nb | prev_pr[i+1];
        if (nb) begin
          nb_cnt++;
          if (led[2][i]) nb_hit++;
        end
      end
    end
    prev_pr = led[2];
  endtask

  task automatic cycle(input string ph, input bit r, input bit en, input logic [1:0] lvl,
                       input logic [N-1:0] msk);
    @(negedge clk);
    rst = r; enable = en; level = lvl; chan_mask = msk;
    if (r) model_reset();
    else   model_step();
    @(posedge clk);
    #1;
    check_outputs(ph);
    tally(en, msk);
  endtask

  task automatic check_rates(input string ph, input int lo, input int hi);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_rate_ch%0d_cnt%0d", ph, i, on_cnt[i]),
            32'(on_cnt[i] >= lo && on_cnt[i] <= hi), 32'd1);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #2;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_led%0d", k), 32'(led[k]), 32'd0);
      check($sformatf("rst_lit%0d", k), 32'(lit[k]), 32'd0);
      check($sformatf("rst_stb%0d", k), 32'(stb[k]), 32'd0);
    end

    for (int c = 0; c < 200; c++) cycle("idle", 0, 0, 2'(c % 4), N'(c * 7919));

    clear_tally();
    repeat (5000) cycle("l0", 0, 1, 2'd0, '1);
    check_rates("l0", 400, 600);

    clear_tally();
    repeat (5000) cycle("l3", 0, 1, 2'd3, '1);
    check_rates("l3", 2350, 2650);

    for (int c = 0; c < 40; c++) cycle("lvlsweep", 0, 1, 2'(c), N'(18'h2AAAA ^ (c * 37)));
    for (int c = 0; c < 20; c++) cycle("entoggle", 0, (c % 2) == 0, 2'd3, '1);

    repeat (6) cycle("drop", 0, 1, 2'd2, '1);
    cycle("drop", 0, 0, 2'd2, '1);
    repeat (6) cycle("drop", 0, 1, 2'd1, N'(18'h0F0F3));

    clear_tally();
    repeat (1000) cycle("prop", 0, 1, 2'd0, '1);
    check($sformatf("prop_ge90_hit%0d_of%0d", nb_hit, nb_cnt),
          32'(nb_cnt > 0 && nb_hit * 10 >= nb_cnt * 9), 32'd1);

    repeat (100) cycle("mask0", 0, 1, 2'd3, '0);

    repeat (2) cycle("prerst", 0, 1, 2'd3, '1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("arst_led%0d", k), 32'(led[k]), 32'd0);
      check($sformatf("arst_lit%0d", k), 32'(lit[k]), 32'd0);
      check($sformatf("arst_stb%0d", k), 32'(stb[k]), 32'd0);
    end
    repeat (12) cycle("postrst", 0, 1, 2'd3, '1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
